// File: rtl/stream_demux_1_n_if.sv
// Handshake bundle for stream_demux_1_n: single producer side plus N consumer lanes.
// The slave modport is the demux view; the master modport is the producer/consumer environment.
interface stream_demux_1_n_if #(
  parameter int unsigned N      = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned SEL_W = $clog2(N);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  in_bcast;
  logic [N-1:0]          out_valid;
  logic [N-1:0]          out_ready;
  logic [N*DATA_W-1:0]   out_data;
  logic                  drop_err;
  logic [CNT_W-1:0]      drop_cnt;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, drop_err, drop_cnt
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, drop_err, drop_cnt
  );
endinterface

// File: rtl/stream_demux_1_n.sv
// Registered 1-to-N stream demultiplexer: unicast by in_sel or atomic broadcast,
// one-entry output register per lane, out-of-range selects are sunk and counted.
module stream_demux_1_n #(
  parameter int unsigned N      = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  stream_demux_1_n_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e         state_q [N];
  ch_state_e         state_d [N];
  logic [DATA_W-1:0] data_q  [N];

  logic [N-1:0]      can_load;
  logic [N-1:0]      sel_hit;
  logic [N-1:0]      load;
  logic              sel_ok;
  logic              accept;
  logic              drop;
  logic              drop_err_q;
  logic [CNT_W-1:0]  drop_cnt_q;

  // sel_hit is a one-hot decode that stays all-zero for out-of-range selects,
  // so the ready mux below needs no variable index into can_load.
  always_comb begin
    can_load = '0;
    sel_hit  = '0;
    sel_ok   = (32'(bus.in_sel) < N);
    for (int unsigned i = 0; i < N; i++) begin
      can_load[i] = (state_q[i] == EMPTY) | bus.out_ready[i];
      sel_hit[i]  = (32'(bus.in_sel) == i);
    end
  end

  always_comb begin
    bus.in_ready = 1'b1;
    if (bus.in_bcast)
      bus.in_ready = &can_load;
    else if (sel_ok)
      bus.in_ready = |(can_load & sel_hit);
  end

  always_comb begin
    accept = bus.in_valid & bus.in_ready;
    load   = '0;
    if (accept)
      load = bus.in_bcast ? '1 : sel_hit;
    drop   = accept & ~bus.in_bcast & ~sel_ok;
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      if (load[i])
        state_d[i] = FULL;
      else if (bus.out_ready[i])
        state_d[i] = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++)
        state_q[i] <= EMPTY;
    end else begin
      for (int unsigned i = 0; i < N; i++)
        state_q[i] <= state_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++)
        data_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++)
        if (load[i])
          data_q[i] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_err_q <= drop;
      if (drop && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.out_valid = '0;
    bus.out_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.out_valid[i]                  = (state_q[i] == FULL);
      bus.out_data[i*DATA_W +: DATA_W]  = data_q[i];
    end
    bus.drop_err = drop_err_q;
    bus.drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Directed self-checking bench for stream_demux_1_n: one N=16 instance for routing,
// backpressure and broadcast, two N=12 instances for out-of-range drops and counter saturation.
module tb_stream_demux_1_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stream_demux_1_n_if #(.N(16), .DATA_W(8), .CNT_W(8)) b16 ();
  stream_demux_1_n_if #(.N(12), .DATA_W(8), .CNT_W(8)) b12 ();
  stream_demux_1_n_if #(.N(12), .DATA_W(8), .CNT_W(2)) b12s ();

  stream_demux_1_n #(.N(16), .DATA_W(8), .CNT_W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16.slave));
  stream_demux_1_n #(.N(12), .DATA_W(8), .CNT_W(8)) u12 (
    .clk(clk), .rst_n(rst_n), .bus(b12.slave));
  stream_demux_1_n #(.N(12), .DATA_W(8), .CNT_W(2)) u12s (
    .clk(clk), .rst_n(rst_n), .bus(b12s.slave));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b16.in_valid = 1'b0;  b16.in_data = '0;  b16.in_sel = '0;  b16.in_bcast = 1'b0;  b16.out_ready = '1;
    b12.in_valid = 1'b0;  b12.in_data = '0;  b12.in_sel = '0;  b12.in_bcast = 1'b0;  b12.out_ready = '1;
    b12s.in_valid = 1'b0; b12s.in_data = '0; b12s.in_sel = '0; b12s.in_bcast = 1'b0; b12s.out_ready = '1;

    // reset state
    tick(); tick();
    chk("rst_out_valid", 128'(b16.out_valid), 128'h0);
    chk("rst_out_data", 128'(b16.out_data), 128'h0);
    chk("rst_drop_err", 128'(b12.drop_err), 128'h0);
    chk("rst_drop_cnt", 128'(b12.drop_cnt), 128'h0);
    rst_n = 1'b1;
    b16.in_sel = 4'd0; #1;
    chk("rel_ready_sel0", 128'(b16.in_ready), 128'h1);
    b16.in_sel = 4'd15; #1;
    chk("rel_ready_sel15", 128'(b16.in_ready), 128'h1);
    b12.in_sel = 4'd13; #1;
    chk("rel_ready_sel13_n12", 128'(b12.in_ready), 128'h1);

    // unicast
    tick();
    b16.in_valid = 1'b1; b16.in_data = 8'hA5; b16.in_sel = 4'd5; #1;
    chk("uni_ready", 128'(b16.in_ready), 128'h1);
    tick();
    b16.in_valid = 1'b0;
    chk("uni_valid", 128'(b16.out_valid), 128'h0020);
    chk("uni_data5", 128'(b16.out_data[5*8 +: 8]), 128'hA5);
    tick();
    chk("uni_drain", 128'(b16.out_valid), 128'h0);

    // backpressure on ch5
    b16.out_ready = 16'hFFDF;
    b16.in_valid = 1'b1; b16.in_data = 8'h11; b16.in_sel = 4'd5; #1;
    chk("bp_ready_first", 128'(b16.in_ready), 128'h1);
    tick();
    b16.in_data = 8'h22; #1;
    chk("bp_ready_second", 128'(b16.in_ready), 128'h0);
    chk("bp_valid", 128'(b16.out_valid), 128'h0020);
    chk("bp_data5", 128'(b16.out_data[5*8 +: 8]), 128'h11);
    tick();
    chk("bp_hold_valid", 128'(b16.out_valid), 128'h0020);
    chk("bp_hold_data5", 128'(b16.out_data[5*8 +: 8]), 128'h11);

    // independence: ch6 loads while ch5 is stalled
    b16.in_data = 8'h33; b16.in_sel = 4'd6; #1;
    chk("ind_ready6", 128'(b16.in_ready), 128'h1);
    tick();
    chk("ind_valid", 128'(b16.out_valid), 128'h0060);
    chk("ind_data6", 128'(b16.out_data[6*8 +: 8]), 128'h33);
    chk("ind_data5", 128'(b16.out_data[5*8 +: 8]), 128'h11);

    // release ch5: pass-through with no bubble
    b16.in_data = 8'h22; b16.in_sel = 4'd5; b16.out_ready = '1; #1;
    chk("bp_release_ready", 128'(b16.in_ready), 128'h1);
    tick();
    b16.in_valid = 1'b0;
    chk("bp_pass_valid", 128'(b16.out_valid), 128'h0020);
    chk("bp_pass_data5", 128'(b16.out_data[5*8 +: 8]), 128'h22);
    tick();
    chk("bp_empty", 128'(b16.out_valid), 128'h0);

    // broadcast
    b16.in_valid = 1'b1; b16.in_bcast = 1'b1; b16.in_data = 8'h7E; #1;
    chk("bc_ready", 128'(b16.in_ready), 128'h1);
    tick();
    b16.in_valid = 1'b0;
    chk("bc_valid", 128'(b16.out_valid), 128'hFFFF);
    chk("bc_data", 128'(b16.out_data), {16{8'h7E}});

    // broadcast blocked by stalled ch9
    b16.out_ready = 16'hFDFF;
    b16.in_valid = 1'b1; b16.in_data = 8'h5A; #1;
    chk("bc_stall_ready", 128'(b16.in_ready), 128'h0);
    tick();
    chk("bc_stall_valid", 128'(b16.out_valid), 128'h0200);
    chk("bc_stall_data9", 128'(b16.out_data[9*8 +: 8]), 128'h7E);
    chk("bc_stall_data0", 128'(b16.out_data[0 +: 8]), 128'h7E);
    chk("bc_stall_ready2", 128'(b16.in_ready), 128'h0);
    b16.out_ready = '1; #1;
    chk("bc_unstall_ready", 128'(b16.in_ready), 128'h1);
    tick();
    b16.in_valid = 1'b0; b16.in_bcast = 1'b0;
    chk("bc2_valid", 128'(b16.out_valid), 128'hFFFF);
    chk("bc2_data", 128'(b16.out_data), {16{8'h5A}});
    tick();
    chk("bc2_drain", 128'(b16.out_valid), 128'h0);

    // N=12: highest legal select, then three drops
    b12.in_valid = 1'b1; b12.in_sel = 4'd11; b12.in_data = 8'hC3; #1;
    chk("n12_ready11", 128'(b12.in_ready), 128'h1);
    tick();
    b12.in_valid = 1'b0;
    chk("n12_valid11", 128'(b12.out_valid), 128'h800);
    chk("n12_data11", 128'(b12.out_data[11*8 +: 8]), 128'hC3);
    chk("n12_no_err", 128'(b12.drop_err), 128'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      b12.in_valid = 1'b1; b12.in_sel = 4'd13; b12.in_data = 8'(8'h90 + k); #1;
      chk("drop_ready", 128'(b12.in_ready), 128'h1);
      tick();
      b12.in_valid = 1'b0;
      chk("drop_err_pulse", 128'(b12.drop_err), 128'h1);
      chk("drop_cnt", 128'(b12.drop_cnt), 128'(k));
      chk("drop_no_valid", 128'(b12.out_valid), 128'h0);
      tick();
      chk("drop_err_low", 128'(b12.drop_err), 128'h0);
    end

    // CNT_W=2 saturation over five back-to-back drops
    b12s.in_valid = 1'b1; b12s.in_sel = 4'd15; b12s.in_data = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sat_cnt", 128'(b12s.drop_cnt), (k < 3) ? 128'(k) : 128'h3);
      chk("sat_err", 128'(b12s.drop_err), 128'h1);
    end
    b12s.in_valid = 1'b0;
    tick();
    chk("sat_hold", 128'(b12s.drop_cnt), 128'h3);
    chk("sat_err_low", 128'(b12s.drop_err), 128'h0);

    // asynchronous reset with ch3 FULL and stalled
    b16.out_ready = 16'hFFF7;
    b16.in_valid = 1'b1; b16.in_sel = 4'd3; b16.in_data = 8'h44;
    tick();
    b16.in_valid = 1'b0;
    chk("pre_rst_valid", 128'(b16.out_valid), 128'h0008);
    rst_n = 1'b0; #1;
    chk("arst_valid", 128'(b16.out_valid), 128'h0);
    chk("arst_data", 128'(b16.out_data), 128'h0);
    chk("arst_cnt12", 128'(b12.drop_cnt), 128'h0);
    chk("arst_cnt12s", 128'(b12s.drop_cnt), 128'h0);
    tick();
    rst_n = 1'b1;
    b16.in_sel = 4'd3; #1;
    chk("post_rst_ready3", 128'(b16.in_ready), 128'h1);
    tick();
    chk("post_rst_valid", 128'(b16.out_valid), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
